// File: rtl/pc_link_pkg.sv
// pc_link_pkg: framing constants, type codes, info-word layout and TX FSM states for the PC link
package pc_link_pkg;
  localparam logic [15:0] SYNC_WORD = 16'hEB90;
  localparam logic [15:0] TAIL_WORD = 16'h09D7;
  localparam logic [15:0] TYPE_INST = 16'h000A;
  localparam logic [15:0] TYPE_INTER = 16'h0008;
  localparam int OVERHEAD = 13;
  localparam int INFO_TYPE_LSB = 56;
  localparam int INFO_ADDR_LSB = 40;
  localparam int INFO_LEN_LSB = 0;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE, S_DONE} tx_state_t;
  function automatic logic [71:0] info_word(logic [15:0] t, logic [11:0] a, logic [31:0] l);
    return (72'(t) << INFO_TYPE_LSB) | (72'(a) << INFO_ADDR_LSB) | (72'(l) << INFO_LEN_LSB);
  endfunction
endpackage

// File: rtl/pc_tx_resp_if.sv
// pc_tx_resp_if: frame-data BRAM write port and frame-info FIFO push port
interface pc_tx_resp_if;
  logic fdram_wr_req;
  logic fdram_wr_ack;
  logic fdram_wr_done;
  logic fdram_wr_en;
  logic [11:0] fdram_wr_addr;
  logic [7:0] fdram_wr_data;
  logic fififo_wr_en;
  logic [71:0] fififo_wr_data;
  logic fififo_full;
  modport master (
    output fdram_wr_req, fdram_wr_done, fdram_wr_en, fdram_wr_addr, fdram_wr_data, fififo_wr_en, fififo_wr_data,
    input fdram_wr_ack, fififo_full
  );
  modport slave (
    input fdram_wr_req, fdram_wr_done, fdram_wr_en, fdram_wr_addr, fdram_wr_data, fififo_wr_en, fififo_wr_data,
    output fdram_wr_ack, fififo_full
  );
endinterface

// File: rtl/pc_tx_byte_mux.sv
// pc_tx_byte_mux: selects the frame byte at a given index from the snapshotted frame fields
module pc_tx_byte_mux
  import pc_link_pkg::*;
(
  input  logic [15:0] ftype,
  input  logic [4:0]  flen,
  input  logic [15:0] seq,
  input  logic [47:0] fpay,
  input  logic [4:0]  idx,
  input  logic [7:0]  csum,
  output logic [7:0]  frame_byte
);
  logic [79:0] hdr_sh;
  logic [47:0] pay_sh;
  logic [4:0] pidx;
  always_comb begin
    pidx = idx - 5'd10;
    hdr_sh = {SYNC_WORD, ftype, 27'h0, flen, seq} << {idx, 3'b000};
    pay_sh = fpay << {pidx, 3'b000};
    frame_byte = idx == flen - 5'd1 ? TAIL_WORD[7:0] :
                 idx == flen - 5'd2 ? TAIL_WORD[15:8] :
                 idx == flen - 5'd3 ? csum :
                 idx >= 5'd10 ? pay_sh[47:40] : hdr_sh[79:72];
  end
endmodule

// File: rtl/pc_tx_resp.sv
// pc_tx_resp: frames captured INST/INTER responses into the TX BRAM ring and pushes an info word per frame
// Optional PC_TX_SEQ_EN: places a 16-bit running sequence number in frame bytes 8-9.
module pc_tx_resp
  import pc_link_pkg::*;
#(
  parameter int U_DLY = 1
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [15:0] inst_resp_data,
  input  logic        inst_resp_data_valid,
  input  logic [15:0] inter_rd_addr,
  input  logic [31:0] inter_rd_data,
  input  logic        inter_rd_valid,
  pc_tx_resp_if.master tx,
  output logic        tx_drop
);
  tx_state_t state, state_nxt;
  logic inst_pend, inter_pend, take_inst, take_inter;
  logic [15:0] inst_d, inter_a, ftype, seq;
  logic [31:0] inter_d;
  logic [47:0] fpay;
  logic [4:0] flen, idx;
  logic [7:0] csum, byte_d;
  logic [11:0] wptr;
  logic unused_dly;
  assign unused_dly = U_DLY != 0;
  assign take_inst = state == S_IDLE && inst_pend && !tx.fififo_full;
  assign take_inter = state == S_IDLE && !inst_pend && inter_pend && !tx.fififo_full;
  always_ff @(posedge clk_sys)
    if (rst) state <= S_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == S_IDLE ? (take_inst || take_inter ? S_REQ : S_IDLE) :
                state == S_REQ ? (tx.fdram_wr_ack ? S_WRITE : S_REQ) :
                state == S_WRITE ? (idx == flen - 5'd1 ? S_DONE : S_WRITE) : S_IDLE;
    tx.fdram_wr_req = state == S_REQ;
    tx.fdram_wr_en = state == S_WRITE;
    tx.fdram_wr_addr = tx.fdram_wr_en ? wptr + 12'(idx) : 12'h0;
    tx.fdram_wr_data = tx.fdram_wr_en ? byte_d : 8'h0;
    tx.fdram_wr_done = state == S_DONE;
    tx.fififo_wr_en = state == S_DONE;
    tx.fififo_wr_data = state == S_DONE ? info_word(ftype, wptr, 32'(flen)) : 72'h0;
  end
  // A strobe landing on the same edge as its slot's snapshot becomes a fresh pending entry, not a drop
  always_ff @(posedge clk_sys)
    if (rst) begin
      inst_pend <= 1'b0;
      inter_pend <= 1'b0;
      tx_drop <= 1'b0;
      wptr <= 12'h0;
      idx <= 5'd0;
      csum <= 8'h0;
    end else begin
      inst_pend <= inst_resp_data_valid | (inst_pend & ~take_inst);
      inter_pend <= inter_rd_valid | (inter_pend & ~take_inter);
      tx_drop <= (inst_resp_data_valid & inst_pend & ~take_inst) | (inter_rd_valid & inter_pend & ~take_inter);
      if (inst_resp_data_valid) inst_d <= inst_resp_data;
      if (inter_rd_valid) begin
        inter_a <= inter_rd_addr;
        inter_d <= inter_rd_data;
      end
      if (take_inst || take_inter) begin
        ftype <= take_inst ? TYPE_INST : TYPE_INTER;
        flen <= take_inst ? 5'(OVERHEAD + 2) : 5'(OVERHEAD + 6);
        fpay <= take_inst ? {inst_d, 32'h0} : {inter_a, inter_d};
      end
      idx <= state == S_WRITE ? idx + 5'd1 : 5'd0;
      csum <= state != S_WRITE ? 8'h0 : idx >= 5'd2 && idx <= flen - 5'd4 ? csum + byte_d : csum;
      if (state == S_DONE) wptr <= wptr + 12'(flen);
    end
`ifdef PC_TX_SEQ_EN
  always_ff @(posedge clk_sys)
    if (rst) seq <= 16'h0;
    else if (state == S_DONE) seq <= seq + 16'd1;
`else
  assign seq = 16'h0;
`endif
  pc_tx_byte_mux u_mux (
    .ftype(ftype),
    .flen(flen),
    .seq(seq),
    .fpay(fpay),
    .idx(idx),
    .csum(csum),
    .frame_byte(byte_d)
  );
endmodule

// File: tb/tb_pc_tx_resp.sv
// tb_pc_tx_resp: scoreboard bench; stimulus queues expected bytes/info words, a negedge monitor checks them
module tb_pc_tx_resp;
  logic clk_sys = 1'b0;
  logic rst = 1'b1;
  logic [15:0] inst_resp_data = '0;
  logic inst_resp_data_valid = 1'b0;
  logic [15:0] inter_rd_addr = '0;
  logic [31:0] inter_rd_data = '0;
  logic inter_rd_valid = 1'b0;
  logic tx_drop;
  pc_tx_resp_if bus ();
  pc_tx_resp dut (
    .clk_sys(clk_sys),
    .rst(rst),
    .inst_resp_data(inst_resp_data),
    .inst_resp_data_valid(inst_resp_data_valid),
    .inter_rd_addr(inter_rd_addr),
    .inter_rd_data(inter_rd_data),
    .inter_rd_valid(inter_rd_valid),
    .tx(bus.master),
    .tx_drop(tx_drop)
  );
  always #5 clk_sys = ~clk_sys;
  int errors = 0;
  int checks = 0;
  int drops = 0;
  logic [19:0] bq[$];
  logic [71:0] iq[$];
  logic [11:0] exp_ptr = 12'h0;
  logic [15:0] exp_seq = 16'h0;
  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  // Independent frame builder: queues every expected {addr,byte} and the info word
  task automatic model_frame(input logic [15:0] typ, input logic [47:0] pl, input int n);
    logic [7:0] b[19];
    logic [7:0] s;
    int l;
    l = 13 + n;
    s = 8'h0;
    b[0] = 8'hEB; b[1] = 8'h90; b[2] = typ[15:8]; b[3] = typ[7:0];
    b[4] = 8'h0; b[5] = 8'h0; b[6] = 8'h0; b[7] = 8'(l);
`ifdef PC_TX_SEQ_EN
    b[8] = exp_seq[15:8]; b[9] = exp_seq[7:0];
    exp_seq++;
`else
    b[8] = 8'h0; b[9] = 8'h0;
`endif
    for (int i = 0; i < n; i++) b[10 + i] = pl[47 - 8 * i -: 8];
    for (int i = 2; i <= l - 4; i++) s += b[i];
    b[l - 3] = s; b[l - 2] = 8'h09; b[l - 1] = 8'hD7;
    for (int i = 0; i < l; i++) bq.push_back({exp_ptr + 12'(i), b[i]});
    iq.push_back({typ, 4'h0, exp_ptr, 8'h0, 32'(l)});
    exp_ptr += 12'(l);
  endtask
  always @(negedge clk_sys) if (!rst) begin
    if (bus.fdram_wr_en) begin
      if (bq.size() == 0) chk("unexpected_byte", {52'h0, bus.fdram_wr_addr, bus.fdram_wr_data}, 72'hx);
      else chk("frame_byte", {52'h0, bus.fdram_wr_addr, bus.fdram_wr_data}, {52'h0, bq.pop_front()});
    end
    if (bus.fififo_wr_en) begin
      if (iq.size() == 0) chk("unexpected_push", bus.fififo_wr_data, 72'hx);
      else chk("info_word", bus.fififo_wr_data, iq.pop_front());
    end
    if (bus.fififo_wr_en || bus.fdram_wr_done) chk("done_with_push", 72'(bus.fdram_wr_done), 72'(bus.fififo_wr_en));
    if (tx_drop) drops++;
  end
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic strobe(input bit do_inst, input logic [15:0] d, input bit do_inter, input logic [15:0] a, input logic [31:0] rd);
    inst_resp_data = d; inst_resp_data_valid = do_inst;
    inter_rd_addr = a; inter_rd_data = rd; inter_rd_valid = do_inter;
    tick();
    inst_resp_data_valid = 1'b0; inter_rd_valid = 1'b0;
  endtask
  task automatic req_ack(input int dly);
    int n;
    n = 0;
    while (!bus.fdram_wr_req && n < 50) begin tick(); n++; end
    chk("req_seen", 72'(bus.fdram_wr_req), 72'h1);
    repeat (dly) tick();
    chk("req_held", 72'(bus.fdram_wr_req), 72'h1);
    bus.fdram_wr_ack = 1'b1;
    tick();
    bus.fdram_wr_ack = 1'b0;
    chk("first_byte_after_ack", {bus.fdram_wr_req, bus.fdram_wr_en}, 72'h1);
  endtask
  task automatic serve(input int dly, input bit full_mid);
    int n;
    req_ack(dly);
    bus.fififo_full = full_mid;
    n = 0;
    while (!bus.fdram_wr_done && n < 40) begin tick(); n++; end
    chk("done_seen", 72'(bus.fdram_wr_done), 72'h1);
    tick();
    bus.fififo_full = 1'b0;
  endtask
  task automatic chk_idle_outputs(input string nm);
    chk(nm, {bus.fdram_wr_req, bus.fdram_wr_done, bus.fdram_wr_en, bus.fdram_wr_addr, bus.fdram_wr_data,
             bus.fififo_wr_en, tx_drop}, 72'h0);
    chk({nm, "_info"}, bus.fififo_wr_data, 72'h0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [11:0] start;
    int d0, n;
    bus.fdram_wr_ack = 1'b0;
    bus.fififo_full = 1'b0;
    repeat (3) tick();
    chk_idle_outputs("reset_outputs");
    rst = 1'b0;
    tick();
    model_frame(16'h000A, {16'h1234, 32'h0}, 2);
    strobe(1, 16'h1234, 0, 16'h0, 32'h0);
    serve(2, 0);
    model_frame(16'h0008, {16'h0100, 32'hDEADBEEF}, 6);
    strobe(0, 16'h0, 1, 16'h0100, 32'hDEADBEEF);
    serve(0, 1);
    model_frame(16'h000A, {16'hA55A, 32'h0}, 2);
    model_frame(16'h0008, {16'h0200, 32'h01234567}, 6);
    strobe(1, 16'hA55A, 1, 16'h0200, 32'h01234567);
    serve(2, 0);
    serve(1, 0);
    for (int i = 0; i < 266; i++) begin
      if (i % 33 == 5) begin
        model_frame(16'h0008, {16'(i), 32'(i * 7919)}, 6);
        strobe(0, 16'h0, 1, 16'(i), 32'(i * 7919));
      end else begin
        model_frame(16'h000A, {16'(i * 3), 32'h0}, 2);
        strobe(1, 16'(i * 3), 0, 16'h0, 32'h0);
      end
      serve(i % 3, 0);
    end
    model_frame(16'h000A, {16'hBEEF, 32'h0}, 2);
    strobe(1, 16'hBEEF, 0, 16'h0, 32'h0);
    serve(1, 0);
    bus.fififo_full = 1'b1;
    d0 = drops;
    strobe(1, 16'h1111, 0, 16'h0, 32'h0);
    strobe(1, 16'h2222, 0, 16'h0, 32'h0);
    repeat (5) begin
      chk("no_req_when_full", 72'(bus.fdram_wr_req), 72'h0);
      tick();
    end
    chk("one_drop", 72'(drops - d0), 72'h1);
    model_frame(16'h000A, {16'h2222, 32'h0}, 2);
    bus.fififo_full = 1'b0;
    serve(1, 0);
    start = exp_ptr;
    model_frame(16'h000A, {16'h5A5A, 32'h0}, 2);
    strobe(1, 16'h5A5A, 0, 16'h0, 32'h0);
    req_ack(1);
    n = 0;
    while (!(bus.fdram_wr_en && bus.fdram_wr_addr == start + 12'd5) && n < 20) begin tick(); n++; end
    chk("reached_byte5", {bus.fdram_wr_en, bus.fdram_wr_addr}, {1'b1, start + 12'd5});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_outputs("after_mid_reset");
    bq.delete();
    iq.delete();
    exp_ptr = 12'h0;
    exp_seq = 16'h0;
    repeat (4) tick();
    model_frame(16'h000A, {16'hC0DE, 32'h0}, 2);
    strobe(1, 16'hC0DE, 0, 16'h0, 32'h0);
    serve(0, 0);
    repeat (3) tick();
    chk("bytes_drained", 72'(bq.size()), 72'h0);
    chk("infos_drained", 72'(iq.size()), 72'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
